boreal_error_monitor: RTL and testbench
=======================================

BOREAL_ERROR_MONITOR -- requirements
Module: boreal_error_monitor

Interface
REQ-001 Parameter EPS_W, default 16: width of the signed prediction-error sample.
REQ-002 Parameter AVG_SHIFT, default 2: leak shift of the error average (1..8).
REQ-003 Parameter THRESH_HI, default 1000: unsigned alarm-entry threshold on the average.
REQ-004 Parameter THRESH_LO, default 600: unsigned alarm-exit threshold; SHALL be <= THRESH_HI.
REQ-005 Parameter SUSTAIN_N, default 4: consecutive qualifying samples for entry and for exit (>=2).
REQ-006 Parameter HOLD_N, default 16: minimum alarm clock cycles before exit qualification starts.
REQ-007 Parameter STALE_CYC, default 64: sample-gap clock cycles that raise stale_fault.
REQ-008 clk  in  1  single system clock; all state changes on rising edge.
REQ-009 rst  in  1  reset, synchronous, active-high.
REQ-010 eps_in  in  EPS_W  signed prediction error epsilon.
REQ-011 eps_valid  in  1  eps_in valid this cycle; single-cycle qualifier, no backpressure.
REQ-012 high_error_flag  out  1  registered; sustained high error, feeds safety-escalation high_error_flag.
REQ-013 stale_fault  out  1  registered; error stream stalled.
REQ-014 eps_avg  out  EPS_W-1  registered unsigned leaky average of |eps_in|.
REQ-015 mon_state  out  2  registered FSM state: 00 NOMINAL, 01 ARMING, 10 ALARM, 11 RECOVER.

Function
REQ-016 mag = |eps_in|, saturated: most-negative input maps to 2^(EPS_W-1)-1 (32767 at defaults).
REQ-017 On eps_valid: avg_next = avg + ((mag - avg) >>> AVG_SHIFT), computed at EPS_W+1 signed width, arithmetic shift, result registered into eps_avg; without eps_valid eps_avg holds.
REQ-018 All threshold compares use avg_next of the same valid sample; "high" = avg_next >= THRESH_HI, "low" = avg_next <= THRESH_LO.
REQ-019 NOMINAL: flag 0; valid high sample -> ARMING, qual_cnt=1; otherwise stay.
REQ-020 ARMING: flag 0; valid high sample increments qual_cnt, at SUSTAIN_N -> ALARM; valid non-high sample -> NOMINAL, qual_cnt=0; cycles without eps_valid neither count nor reset.
REQ-021 ALARM entry clears hold_cnt; hold_cnt increments each clock, saturating at HOLD_N; flag 1.
REQ-022 ALARM: valid low sample with hold_cnt == HOLD_N -> RECOVER, qual_cnt=1; low samples earlier are ignored.
REQ-023 RECOVER: flag 1; valid low sample increments qual_cnt, at SUSTAIN_N -> NOMINAL; valid non-low sample -> ALARM without clearing hold_cnt.
REQ-024 high_error_flag SHALL be 1 exactly when registered state is ALARM or RECOVER; it rises the cycle after the edge sampling the SUSTAIN_N-th high sample.
REQ-025 gap_cnt clears on every eps_valid, else increments saturating at STALE_CYC; stale_fault = (gap_cnt == STALE_CYC), so it falls the cycle after the next eps_valid.
REQ-026 stale_fault SHALL NOT alter FSM state or eps_avg.
REQ-027 qual_cnt, hold_cnt, gap_cnt SHALL never wrap.

Reset
REQ-028 While rst is 1 at a clock edge: state NOMINAL, eps_avg 0, qual_cnt/hold_cnt/gap_cnt 0, high_error_flag 0, stale_fault 0; eps_valid in that cycle is ignored.
REQ-029 Reset mid-ALARM/RECOVER SHALL drop high_error_flag the cycle after the reset edge; no state is retained.

Verification (defaults)
REQ-030 Reset, then eps_in=+4000 valid every cycle -> eps_avg 1000,1750,2312,2734; flag rises after 4th sample edge; mon_state 01 for 3 cycles then 10.
REQ-031 eps_in=-32768 single valid sample from reset -> eps_avg=8191.
REQ-032 After ALARM entry, eps_in=0 every cycle -> no RECOVER before 16 cycles in ALARM; then RECOVER, 4 low samples, flag falls; eps_avg decays to 0.
REQ-033 In ARMING (qual_cnt=2) apply eps_in=0 -> state NOMINAL, flag never asserted.
REQ-034 No eps_valid for 64 cycles after reset -> stale_fault 1 at 64th cycle; one eps_valid -> stale_fault 0 next cycle.
REQ-035 rst pulsed while flag=1 in RECOVER -> all outputs 0 next cycle; re-entry requires 4 fresh high samples.

Source files
------------

// File: rtl/boreal_error_monitor.sv
// Prediction-error health monitor: leaky average of |epsilon| with a hysteretic
// NOMINAL/ARMING/ALARM/RECOVER alarm FSM and an input-stall detector.
module boreal_error_monitor #(
    parameter int EPS_W     = 16,
    parameter int AVG_SHIFT = 2,
    parameter int THRESH_HI = 1000,
    parameter int THRESH_LO = 600,
    parameter int SUSTAIN_N = 4,
    parameter int HOLD_N    = 16,
    parameter int STALE_CYC = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [EPS_W-1:0] eps_in,
    input  logic                    eps_valid,
    output logic                    high_error_flag,
    output logic                    stale_fault,
    output logic [EPS_W-2:0]        eps_avg,
    output logic [1:0]              mon_state
);

    localparam int QW = $clog2(SUSTAIN_N + 1);
    localparam int HW = $clog2(HOLD_N + 1);
    localparam int GW = $clog2(STALE_CYC + 1);

    localparam logic signed [EPS_W:0] TH_HI_W  = (EPS_W+1)'(THRESH_HI);
    localparam logic signed [EPS_W:0] TH_LO_W  = (EPS_W+1)'(THRESH_LO);
    localparam logic [QW-1:0]         QUAL_END = QW'(SUSTAIN_N);
    localparam logic [HW-1:0]         HOLD_MAX = HW'(HOLD_N);
    localparam logic [GW-1:0]         GAP_MAX  = GW'(STALE_CYC);

    typedef enum logic [1:0] {
        NOMINAL = 2'b00,
        ARMING  = 2'b01,
        ALARM   = 2'b10,
        RECOVER = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [QW-1:0]     qual_q, qual_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [EPS_W-2:0]  avg_q, avg_d;
    logic              flag_q, flag_d;
    logic              stale_q, stale_d;

    logic [EPS_W-1:0]  mag_full;
    logic [EPS_W-2:0]  mag;
    logic signed [EPS_W:0] diff, step, avg_wide;
    logic              is_high, is_low;

    // Only the most-negative input leaves the sign bit set after negation.
    always_comb begin
        mag_full = eps_in[EPS_W-1] ? ('0 - $unsigned(eps_in)) : $unsigned(eps_in);
        mag      = mag_full[EPS_W-1] ? '1 : mag_full[EPS_W-2:0];
        diff     = $signed({2'b00, mag}) - $signed({2'b00, avg_q});
        step     = diff >>> AVG_SHIFT;
        avg_wide = $signed({2'b00, avg_q}) + step;
        is_high  = eps_valid && (avg_wide >= TH_HI_W);
        is_low   = eps_valid && (avg_wide <= TH_LO_W);
        avg_d    = eps_valid ? avg_wide[EPS_W-2:0] : avg_q;
    end

    always_comb begin
        state_d = state_q;
        qual_d  = qual_q;
        hold_d  = hold_q;
        if ((state_q == ALARM || state_q == RECOVER) && hold_q != HOLD_MAX)
            hold_d = hold_q + HW'(1);
        case (state_q)
            NOMINAL: begin
                qual_d = '0;
                hold_d = '0;
                if (is_high) begin
                    state_d = ARMING;
                    qual_d  = QW'(1);
                end
            end
            ARMING: begin
                if (eps_valid) begin
                    if (is_high) begin
                        if (qual_q + QW'(1) == QUAL_END) begin
                            state_d = ALARM;
                            qual_d  = '0;
                            hold_d  = '0;
                        end else begin
                            qual_d = qual_q + QW'(1);
                        end
                    end else begin
                        state_d = NOMINAL;
                        qual_d  = '0;
                    end
                end
            end
            ALARM: begin
                if (is_low && hold_q == HOLD_MAX) begin
                    state_d = RECOVER;
                    qual_d  = QW'(1);
                end
            end
            RECOVER: begin
                // Falling back to ALARM keeps hold_cnt, so exit may requalify at once.
                if (eps_valid) begin
                    if (is_low) begin
                        if (qual_q + QW'(1) == QUAL_END) begin
                            state_d = NOMINAL;
                            qual_d  = '0;
                        end else begin
                            qual_d = qual_q + QW'(1);
                        end
                    end else begin
                        state_d = ALARM;
                        qual_d  = '0;
                    end
                end
            end
            default: state_d = NOMINAL;
        endcase
    end

    always_comb begin
        gap_d   = eps_valid ? '0 : ((gap_q == GAP_MAX) ? gap_q : gap_q + GW'(1));
        stale_d = (gap_d == GAP_MAX);
        flag_d  = (state_d == ALARM) || (state_d == RECOVER);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NOMINAL;
            qual_q  <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            avg_q   <= '0;
            flag_q  <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            state_q <= state_d;
            qual_q  <= qual_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            avg_q   <= avg_d;
            flag_q  <= flag_d;
            stale_q <= stale_d;
        end
    end

    assign high_error_flag = flag_q;
    assign stale_fault     = stale_q;
    assign eps_avg         = avg_q;
    assign mon_state       = state_q;

endmodule

// File: tb/tb_boreal_error_monitor.sv
// Bench for boreal_error_monitor: constant vector table, reference model with a
// scoreboard queue, and hand-built sequences for dwell, stall and reset cases.
module tb_boreal_error_monitor;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               eps_valid = 1'b0;
    logic signed [15:0] eps_in = '0;
    logic               high_error_flag;
    logic               stale_fault;
    logic [14:0]        eps_avg;
    logic [1:0]         mon_state;

    always #5 clk = ~clk;

    boreal_error_monitor dut (
        .clk             (clk),
        .rst             (rst),
        .eps_in          (eps_in),
        .eps_valid       (eps_valid),
        .high_error_flag (high_error_flag),
        .stale_fault     (stale_fault),
        .eps_avg         (eps_avg),
        .mon_state       (mon_state)
    );

    typedef struct {
        int avg;
        int st;
        bit flag;
        bit stale;
    } exp_t;

    typedef struct {
        bit   r;
        bit   v;
        int   e;
        exp_t x;
    } vec_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    int m_avg, m_st, m_qual, m_hold, m_gap;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int fdiv4(input int d);
        return (d >= 0) ? d / 4 : -((-d + 3) / 4);
    endfunction

    task automatic model(input bit r, input bit v, input int e, output exp_t x);
        int mag, an, ns, h0;
        bit hi, lo;
        if (r) begin
            m_avg = 0; m_st = 0; m_qual = 0; m_hold = 0; m_gap = 0;
        end else begin
            mag = (e < 0) ? -e : e;
            if (mag > 32767) mag = 32767;
            an = v ? m_avg + fdiv4(mag - m_avg) : m_avg;
            hi = v && (an >= 1000);
            lo = v && (an <= 600);
            ns = m_st;
            h0 = m_hold;
            if (m_st >= 2 && m_hold < 16) m_hold++;
            case (m_st)
                0: if (hi) begin ns = 1; m_qual = 1; end
                1: if (v) begin
                       if (hi) begin
                           m_qual++;
                           if (m_qual == 4) begin ns = 2; m_qual = 0; m_hold = 0; end
                       end else begin ns = 0; m_qual = 0; end
                   end
                2: if (lo && h0 == 16) begin ns = 3; m_qual = 1; end
                default: if (v) begin
                       if (lo) begin
                           m_qual++;
                           if (m_qual == 4) begin ns = 0; m_qual = 0; end
                       end else begin ns = 2; m_qual = 0; end
                   end
            endcase
            m_gap = v ? 0 : ((m_gap < 64) ? m_gap + 1 : 64);
            m_avg = an;
            m_st  = ns;
        end
        x.avg = m_avg; x.st = m_st; x.flag = (m_st >= 2); x.stale = (m_gap == 64);
    endtask

    task automatic apply(input bit r, input bit v, input int e);
        exp_t x;
        rst = r; eps_valid = v; eps_in = 16'(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            x = sbq.pop_front();
            chk("eps_avg", int'(eps_avg), x.avg);
            chk("mon_state", int'(mon_state), x.st);
            chk("high_error_flag", int'(high_error_flag), int'(x.flag));
            chk("stale_fault", int'(stale_fault), int'(x.stale));
        end
    endtask

    task automatic step(input bit r, input bit v, input int e);
        exp_t x;
        model(r, v, e, x);
        sbq.push_back(x);
        apply(r, v, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        exp_t dummy;
        int   a_cnt, r_cnt, n;
        bit   flag_seen;

        tbl[0] = '{1'b1, 1'b1, 4000, '{0,    0, 1'b0, 1'b0}};
        tbl[1] = '{1'b1, 1'b0, 0,    '{0,    0, 1'b0, 1'b0}};
        tbl[2] = '{1'b0, 1'b1, 4000, '{1000, 1, 1'b0, 1'b0}};
        tbl[3] = '{1'b0, 1'b1, 4000, '{1750, 1, 1'b0, 1'b0}};
        tbl[4] = '{1'b0, 1'b1, 4000, '{2312, 1, 1'b0, 1'b0}};
        tbl[5] = '{1'b0, 1'b1, 4000, '{2734, 2, 1'b1, 1'b0}};

        for (int i = 0; i < 6; i++) begin
            model(tbl[i].r, tbl[i].v, tbl[i].e, dummy);
            sbq.push_back(tbl[i].x);
            apply(tbl[i].r, tbl[i].v, tbl[i].e);
        end

        // Decay from ALARM: dwell in ALARM, then RECOVER, then back to zero.
        a_cnt = 1; r_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 1'b1, 0);
            if (mon_state == 2'b10) a_cnt++;
            if (mon_state == 2'b11) r_cnt++;
        end
        chk("alarm_dwell", a_cnt, 17);
        chk("recover_dwell", r_cnt, 3);
        chk("decay_avg_zero", int'(eps_avg), 0);
        chk("decay_flag_low", int'(high_error_flag), 0);

        // Most-negative input saturates.
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, -32768);
        chk("neg_sat_avg", int'(eps_avg), 8191);

        // ARMING abort with an idle cycle that must not disturb qual_cnt.
        flag_seen = 1'b0;
        step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 4000);  flag_seen |= high_error_flag;
        step(1'b0, 1'b0, 0);     flag_seen |= high_error_flag;
        step(1'b0, 1'b1, 1000);  flag_seen |= high_error_flag;
        chk("arming_q2_state", int'(mon_state), 1);
        step(1'b0, 1'b1, 0);     flag_seen |= high_error_flag;
        chk("arming_abort_state", int'(mon_state), 0);
        chk("arming_abort_avg", int'(eps_avg), 750);
        chk("arming_flag_never", int'(flag_seen), 0);

        // Stall detection.
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 63; i++) step(1'b0, 1'b0, 0);
        chk("stale_63", int'(stale_fault), 0);
        step(1'b0, 1'b0, 0);
        chk("stale_64", int'(stale_fault), 1);
        step(1'b0, 1'b1, 0);
        chk("stale_clear", int'(stale_fault), 0);

        // RECOVER -> ALARM keeps hold, then reset while in RECOVER.
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4000);
        n = 0;
        while (mon_state != 2'b11 && n < 40) begin step(1'b0, 1'b1, 0); n++; end
        chk("reach_recover", int'(mon_state), 3);
        step(1'b0, 1'b1, 4000);
        chk("recover_to_alarm", int'(mon_state), 2);
        n = 0;
        while (mon_state != 2'b11 && n < 40) begin step(1'b0, 1'b1, 0); n++; end
        chk("realarm_fast", int'(n <= 6), 1);
        chk("reach_recover2", int'(mon_state), 3);
        step(1'b1, 1'b0, 0);
        chk("rst_flag", int'(high_error_flag), 0);
        chk("rst_state", int'(mon_state), 0);
        chk("rst_avg", int'(eps_avg), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4000);
        chk("reentry_3_flag", int'(high_error_flag), 0);
        step(1'b0, 1'b1, 4000);
        chk("reentry_4_flag", int'(high_error_flag), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
